iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are powers of two from 4 to 64.
REQ-002 SHALL have clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have start, input, 1, request to launch an operation.
REQ-005 SHALL have op, input, 4, operation select.
REQ-006 SHALL have a and b, input, WIDTH, operands.
REQ-007 SHALL have cin, input, 1, carry-in for ADD.
REQ-008 SHALL have busy, output, 1, multi-cycle operation in progress.
REQ-009 SHALL have done, output, 1, one-cycle pulse marking a valid result.
REQ-010 SHALL have res, output, WIDTH, registered result.
REQ-011 SHALL have cout and zero, output, 1 each, registered flags.

Function
REQ-012 SHALL accept start only when busy=0, capturing op/a/b/cin at that edge (cycle N); start while busy=1 SHALL be ignored.
REQ-013 SHALL implement single-cycle ops with done=1 at N+1 and busy never set: 0 ADD a+b+cin; 1 SUB a+~b+1; 2 AND; 3 OR; 4 XOR; 5 SHL1 (lsb 0); 6 SHR1 (msb 0).
REQ-014 SHALL implement op 7 SHL and op 8 SHR (logical) by k=b[log2(WIDTH)-1:0], one bit per cycle; done at N+1+k; k=0 gives done at N+1 with res=a.
REQ-015 SHALL implement op 9 MUL as unsigned shift-add, res = low WIDTH bits of a*b, done at N+WIDTH+1.
REQ-016 SHALL use states IDLE and RUN: IDLE->RUN on accepted multi-cycle op; RUN->IDLE when iteration count reaches its terminal value; busy=1 exactly while in RUN.
REQ-017 SHALL assert done for exactly one cycle, with busy=0 in that cycle, so a new start is accepted on the done cycle.
REQ-018 SHALL hold res/cout/zero stable from done until the next done.
REQ-019 SHALL set cout: ADD/SUB carry-out of the MSB (SUB 1 = no borrow); MUL 1 if any high product bit is nonzero; SHL1/SHR1 the bit shifted out; all other ops 0.
REQ-020 SHALL set zero = (res == 0), updated with res.
REQ-021 SHALL treat unused op codes (12-15, and 10-11 when division is not compiled in) as single-cycle: res=0, cout=0, zero=1, done at N+1.

Reset
REQ-022 SHALL, while rst=1 at an edge, force IDLE, busy=0, done=0, res=0, cout=0, zero=0.
REQ-023 SHALL abandon any in-flight operation on reset, with no done generated for it.
REQ-024 SHALL ignore start in any cycle where rst=1.

Configuration
REQ-025 SHALL, with macro ITER_ALU_DIV_EN defined, implement op 10 DIV (unsigned quotient) and op 11 REM (unsigned remainder) by restoring division, done at N+WIDTH+1.
REQ-026 SHALL, for DIV/REM with b=0, return quotient all-ones, remainder a, cout=1, with the same latency.
REQ-027 SHALL, with ITER_ALU_DIV_EN undefined, contain no divider logic, and ops 10/11 SHALL behave per REQ-021.

Verification
REQ-028 ADD a=0xFFFFFFFF b=1 cin=0 -> at N+1: res=0, cout=1, zero=1, done pulse, busy=0 throughout.
REQ-029 MUL a=12345 b=100 -> done at N+33, res=0x0012D644, cout=0; MUL a=0x10000 b=0x10000 -> res=0, cout=1, zero=1.
REQ-030 SHL a=1 b=31 -> busy high N+1..N+31, done at N+32, res=0x80000000; SHR a=0x80 b=0 -> done at N+1, res=0x80.
REQ-031 MUL launched, start with ADD asserted at N+5 (ignored), rst pulsed at N+10 -> busy=0 and res=0 at N+11, no done ever for either op.
REQ-032 ITER_ALU_DIV_EN defined: DIV 100/7 -> res=14; REM 100/7 -> res=2; DIV 5/0 -> res=0xFFFFFFFF, cout=1; undefined: DIV 100/7 -> res=0, zero=1, done at N+1.
REQ-033 WIDTH=8: SUB a=0x05 b=0x07 -> res=0xFE, cout=0; MUL 0x10*0x10 -> done at N+9, res=0x00, cout=1.

Source files
------------

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/add ops plus bit-serial shift, shift-add multiply
// and (when ITER_ALU_DIV_EN is defined) restoring divide/remainder.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             zero
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [3:0]     op_r;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] work, hi, opb;

    logic [LW-1:0]  k;
    logic           is_div_op, is_multi;
    logic [CW-1:0]  n_iter;
    logic [WIDTH:0] sc_res;
    logic [WIDTH:0] mul_sum;
    logic [WIDTH-1:0] nxt_work, nxt_hi, fin_res;
    logic           fin_cout;

    assign k    = b[LW-1:0];
    assign busy = (state == RUN);

`ifdef ITER_ALU_DIV_EN
    assign is_div_op = (op == 4'd10) || (op == 4'd11);
`else
    assign is_div_op = 1'b0;
`endif

    assign is_multi = (op == 4'd9) || is_div_op || (((op == 4'd7) || (op == 4'd8)) && (k != '0));
    assign n_iter   = ((op == 4'd7) || (op == 4'd8)) ? CW'(k) : CW'(WIDTH);

    // {cout, res} for ops that finish at the capture edge
    always_comb begin
        sc_res = '0;
        case (op)
            4'd0:       sc_res = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            4'd1:       sc_res = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            4'd2:       sc_res = {1'b0, a & b};
            4'd3:       sc_res = {1'b0, a | b};
            4'd4:       sc_res = {1'b0, a ^ b};
            4'd5:       sc_res = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            4'd6:       sc_res = {a[0], 1'b0, a[WIDTH-1:1]};
            4'd7, 4'd8: sc_res = {1'b0, a};
            default:    sc_res = '0;
        endcase
    end

`ifdef ITER_ALU_DIV_EN
    logic [WIDTH:0] r_shift;
    logic           ge;
    assign r_shift = {hi, work[WIDTH-1]};
    assign ge      = r_shift >= {1'b0, opb};
`endif

    // One iteration step; mul keeps the product as {hi, work}, div keeps {remainder=hi, quotient=work}
    always_comb begin
        nxt_work = work;
        nxt_hi   = hi;
        mul_sum  = {1'b0, hi} + (work[0] ? {1'b0, opb} : '0);
        case (op_r)
            4'd7: nxt_work = {work[WIDTH-2:0], 1'b0};
            4'd8: nxt_work = {1'b0, work[WIDTH-1:1]};
            4'd9: begin
                nxt_hi   = mul_sum[WIDTH:1];
                nxt_work = {mul_sum[0], work[WIDTH-1:1]};
            end
`ifdef ITER_ALU_DIV_EN
            4'd10, 4'd11: begin
                nxt_hi   = ge ? WIDTH'(r_shift - {1'b0, opb}) : r_shift[WIDTH-1:0];
                nxt_work = {work[WIDTH-2:0], ge};
            end
`endif
            default: ;
        endcase
        fin_res  = nxt_work;
        fin_cout = 1'b0;
        if (op_r == 4'd9) fin_cout = |nxt_hi;
`ifdef ITER_ALU_DIV_EN
        if (op_r == 4'd11) fin_res = nxt_hi;
        if ((op_r == 4'd10) || (op_r == 4'd11)) fin_cout = (opb == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            res   <= '0;
            cout  <= 1'b0;
            zero  <= 1'b0;
            op_r  <= '0;
            cnt   <= '0;
            work  <= '0;
            hi    <= '0;
            opb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r <= op;
                        if (is_multi) begin
                            state <= RUN;
                            cnt   <= n_iter;
                            hi    <= '0;
                            if (op == 4'd9) begin
                                work <= b;
                                opb  <= a;
                            end else begin
                                work <= a;
                                opb  <= b;
                            end
                        end else begin
                            done <= 1'b1;
                            res  <= sc_res[WIDTH-1:0];
                            cout <= sc_res[WIDTH];
                            zero <= (sc_res[WIDTH-1:0] == '0);
                        end
                    end
                end
                RUN: begin
                    work <= nxt_work;
                    hi   <= nxt_hi;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        res   <= fin_res;
                        cout  <= fin_cout;
                        zero  <= (fin_res == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: 32-bit and 8-bit instances, directed vectors,
// expectations queued at issue time and checked by per-instance monitors on done.
module tb_iter_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start = 1'b0, cin = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, cout, zero;
    logic [31:0] res;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, zero8;
    logic [7:0]  res8;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        zero;
        int          at;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .res(res), .cout(cout), .zero(zero)
    );

    iter_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .res(res8), .cout(cout8), .zero(zero8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 1'b1, 1'b0);
            end else begin
                e = q32.pop_front();
                chk("res32", res, e.res);
                chk("cout32", cout, e.cout);
                chk("zero32", zero, e.zero);
                chk("edge32", cyc, e.at);
                chk("busy_on_done32", busy, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1'b1, 1'b0);
            end else begin
                e = q8.pop_front();
                chk("res8", {24'b0, res8}, e.res);
                chk("cout8", cout8, e.cout);
                chk("zero8", zero8, e.zero);
                chk("edge8", cyc, e.at);
            end
        end
    end

    task automatic wait_idle32();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("timeout32", busy, 1'b0);
    endtask

    // Call at a negedge; lat is the number of edges from capture to the done edge.
    task automatic issue32(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                           input logic c, input logic [31:0] er, input logic ec, input int lat);
        exp_t e;
        start = 1'b1; op = o; a = aa; b = bb; cin = c;
        e.res = er; e.cout = ec; e.zero = (er == 32'd0); e.at = cyc + 1 + lat;
        q32.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start32", busy, (lat > 0));
        wait_idle32();
    endtask

    task automatic issue8(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [7:0] er, input logic ec, input int lat);
        exp_t e;
        int n = 0;
        start8 = 1'b1; op8 = o; a8 = aa; b8 = bb; cin8 = 1'b0;
        e.res = {24'b0, er}; e.cout = ec; e.zero = (er == 8'd0); e.at = cyc + 1 + lat;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy8) chk("timeout8", busy8, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_res", res, 32'd0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_zero", zero, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        issue32(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 0);
        issue32(4'd0, 32'd1, 32'd2, 1'b1, 32'd4, 1'b0, 0);
        issue32(4'd1, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 0);
        issue32(4'd1, 32'd7, 32'd5, 1'b0, 32'd2, 1'b1, 0);
        issue32(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 1'b0, 0);
        issue32(4'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        issue32(4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 32'h5555_5555, 1'b0, 0);
        issue32(4'd5, 32'h8000_0001, 32'd0, 1'b0, 32'h0000_0002, 1'b1, 0);
        issue32(4'd6, 32'h8000_0001, 32'd0, 1'b0, 32'h4000_0000, 1'b1, 0);
        issue32(4'd7, 32'd1, 32'd31, 1'b0, 32'h8000_0000, 1'b0, 31);
        issue32(4'd8, 32'h80, 32'd0, 1'b0, 32'h80, 1'b0, 0);
        issue32(4'd8, 32'hF000_0000, 32'h24, 1'b0, 32'h0F00_0000, 1'b0, 4);
        issue32(4'd9, 32'd12345, 32'd100, 1'b0, 32'h0012_D644, 1'b0, 32);
        issue32(4'd9, 32'h1_0000, 32'h1_0000, 1'b0, 32'd0, 1'b1, 32);
        issue32(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 1'b1, 32);
        issue32(4'd12, 32'd9, 32'd3, 1'b1, 32'd0, 1'b0, 0);
        issue32(4'd15, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b0, 0);
`ifdef ITER_ALU_DIV_EN
        issue32(4'd10, 32'd100, 32'd7, 1'b0, 32'd14, 1'b0, 32);
        issue32(4'd11, 32'd100, 32'd7, 1'b0, 32'd2, 1'b0, 32);
        issue32(4'd10, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32);
        issue32(4'd11, 32'd5, 32'd0, 1'b0, 32'd5, 1'b1, 32);
`else
        issue32(4'd10, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
        issue32(4'd11, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
`endif

        // A start while busy must be dropped; only the multiply completes.
        begin
            exp_t e;
            start = 1'b1; op = 4'd9; a = 32'd3; b = 32'd5; cin = 1'b0;
            e.res = 32'd15; e.cout = 1'b0; e.zero = 1'b0; e.at = cyc + 1 + 32;
            q32.push_back(e);
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
            @(negedge clk);
            start = 1'b0;
            wait_idle32();
        end
        @(negedge clk);

        // Reset mid-multiply, with stray starts during busy and during reset: no done at all.
        start = 1'b1; op = 4'd9; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_res", res, 32'd0);
        chk("midrst_done", done, 1'b0);
        repeat (40) @(negedge clk);

        issue8(4'd1, 8'h05, 8'h07, 8'hFE, 1'b0, 0);
        issue8(4'd9, 8'h10, 8'h10, 8'h00, 1'b1, 8);
        issue8(4'd9, 8'h0F, 8'h0F, 8'hE1, 1'b0, 8);
        issue8(4'd7, 8'h01, 8'h0F, 8'h80, 1'b0, 7);
        issue8(4'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 0);

        repeat (5) @(negedge clk);
        chk("queue32_drained", q32.size(), 32'd0);
        chk("queue8_drained", q8.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
